// File: rtl/mem_stage_lsu_if.sv
// MEM-stage signal bundle: pipeline control, EX->MEM bus, SRAM return data,
// and the forwarding/writeback buses produced by the load/store unit.
interface mem_stage_lsu_if #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 32,
  parameter int RF_AW   = 5,
  parameter int STALL_W = 6
);
  logic                        flush;
  logic [STALL_W-1:0]          stall;
  logic [PC_W+RF_AW+XLEN+9:0]  ex_to_mem_bus;
  logic                        data_rvalid;
  logic [XLEN-1:0]             data_sram_rdata;
  logic                        stallreq_mem;
  logic [RF_AW+XLEN+1:0]       mem_to_id_bus;
  logic [PC_W+RF_AW+XLEN:0]    mem_to_wb_bus;
  logic                        align_err;
  logic                        bus_err;

  modport master (
    output flush, stall, ex_to_mem_bus, data_rvalid, data_sram_rdata,
    input  stallreq_mem, mem_to_id_bus, mem_to_wb_bus, align_err, bus_err
  );

  modport slave (
    input  flush, stall, ex_to_mem_bus, data_rvalid, data_sram_rdata,
    output stallreq_mem, mem_to_id_bus, mem_to_wb_bus, align_err, bus_err
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: EX->MEM register plus a load unit for variable-latency
// data SRAM, with load-result forwarding to ID and a watchdog on missing rdata.
module mem_stage_lsu #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 32,
  parameter int RF_AW   = 5,
  parameter int STALL_W = 6,
  parameter int MEM_IDX = 3,
  parameter int TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst,
  mem_stage_lsu_if.slave bus
);
  localparam int EX_W   = PC_W + RF_AW + XLEN + 10;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SEL_B  = XLEN + RF_AW + 1;
  localparam int WEN_LO = XLEN + RF_AW + 5;
  localparam int EN_B   = XLEN + RF_AW + 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_r, state_nxt_s;
  logic [EX_W-1:0] ex_r;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [XLEN-1:0] buf_r, buf_nxt_s;
  logic            bus_err_r, err_set_s;

  logic [PC_W-1:0]  pc_s;
  logic             ram_en_s, sel_rf_res_s, rf_we_s;
  logic [3:0]       ram_wen_s;
  logic [2:0]       load_op_s;
  logic [RF_AW-1:0] rf_waddr_s;
  logic [XLEN-1:0]  ex_result_s, ext_s, rf_wdata_s;
  logic [1:0]       off_s;
  logic             load_s, pending_s, half_s, word_s, wd_hit_s;
  logic             stall_mem_s, bubble_s, upd_s, in_load_s, load_in_s;
  logic             unused_stall_s;

  // Byte/half lane select with sign or zero extension; low offset bits that
  // would make the access misaligned are simply ignored.
  function automatic logic [XLEN-1:0] load_extract(
    input logic [XLEN-1:0] word,
    input logic [2:0]      op,
    input logic [1:0]      off
  );
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (op)
      3'd0:    res = {{(XLEN-8){b[7]}}, b};
      3'd1:    res = {{(XLEN-8){1'b0}}, b};
      3'd2:    res = {{(XLEN-16){h[15]}}, h};
      3'd3:    res = {{(XLEN-16){1'b0}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign {pc_s, ram_en_s, ram_wen_s, load_op_s, sel_rf_res_s, rf_we_s,
          rf_waddr_s, ex_result_s} = ex_r;

  assign off_s          = ex_result_s[1:0];
  assign load_s         = ram_en_s && (ram_wen_s == 4'b0000) && sel_rf_res_s;
  assign stall_mem_s    = bus.stall[MEM_IDX];
  assign bubble_s       = stall_mem_s && !bus.stall[MEM_IDX+1];
  assign upd_s          = bus.flush || bubble_s || !stall_mem_s;
  assign in_load_s      = bus.ex_to_mem_bus[EN_B] && bus.ex_to_mem_bus[SEL_B]
                          && (bus.ex_to_mem_bus[WEN_LO +: 4] == 4'b0000);
  assign load_in_s      = !bus.flush && !stall_mem_s && in_load_s;
  assign unused_stall_s = ^bus.stall;
  assign wd_hit_s       = (TIMEOUT != 0) && (cnt_r == CNT_W'(TIMEOUT - 1));
  assign ext_s          = load_extract(bus.data_sram_rdata, load_op_s, off_s);

  // Access-size decode: loads size by load_op, stores by the byte-enable count.
  always_comb begin
    half_s = 1'b0;
    word_s = 1'b0;
    if (ram_wen_s == 4'b0000) begin
      half_s = (load_op_s == 3'd2) || (load_op_s == 3'd3);
      word_s = (load_op_s >= 3'd4);
    end else begin
      half_s = ($countones(ram_wen_s) == 32'd2);
      word_s = (ram_wen_s == 4'b1111);
    end
  end

  // EX->MEM pipeline register: flush and bubble both squash to all-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r <= '0;
    end else if (bus.flush) begin
      ex_r <= '0;
    end else if (bubble_s) begin
      ex_r <= '0;
    end else if (!stall_mem_s) begin
      ex_r <= bus.ex_to_mem_bus;
    end else begin
      ex_r <= ex_r;
    end
  end

  // Load FSM state, watchdog counter, result buffer and sticky bus error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      buf_r     <= '0;
      bus_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      buf_r     <= buf_nxt_s;
      bus_err_r <= bus_err_r | err_set_s;
    end
  end

  // Next-state logic; the counter is zero everywhere except while still waiting.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = '0;
    buf_nxt_s   = buf_r;
    err_set_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_in_s) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (bus.flush) begin
          state_nxt_s = IDLE;
        end else if (bus.data_rvalid) begin
          if (stall_mem_s) begin
            state_nxt_s = DONE;
            buf_nxt_s   = ext_s;
          end else if (load_in_s) begin
            state_nxt_s = WAIT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (wd_hit_s) begin
          state_nxt_s = DONE;
          buf_nxt_s   = '0;
          err_set_s   = 1'b1;
        end else begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      DONE: begin
        if (upd_s) begin
          state_nxt_s = load_in_s ? WAIT : IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign pending_s  = load_s && (state_r == WAIT) && !bus.data_rvalid;
  assign rf_wdata_s = !load_s ? ex_result_s :
                      ((state_r == WAIT) && bus.data_rvalid) ? ext_s : buf_r;

  assign bus.stallreq_mem  = pending_s;
  assign bus.mem_to_id_bus = {pending_s, rf_we_s, rf_waddr_s, rf_wdata_s};
  assign bus.mem_to_wb_bus = {pc_s, rf_we_s && !pending_s, rf_waddr_s, rf_wdata_s};
  assign bus.align_err     = ram_en_s && ((half_s && off_s[0]) ||
                                          (word_s && (off_s != 2'b00)));
  assign bus.bus_err       = bus_err_r;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: writebacks are checked against a queue of
// expected WB words filled as instructions are issued.
module tb_mem_stage_lsu;
  localparam int XLEN    = 32;
  localparam int PC_W    = 32;
  localparam int RF_AW   = 5;
  localparam int STALL_W = 6;
  localparam int MEM_IDX = 3;
  localparam int TIMEOUT = 4;
  localparam int EX_W    = PC_W + RF_AW + XLEN + 10;
  localparam int WB_W    = PC_W + RF_AW + XLEN + 1;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;
  logic [WB_W-1:0] sb_q[$];

  logic [EX_W-1:0] nop_e, lb_e, lhu_e, alu_e, st_e, lw_e, lb2_e, lh_e, lw2_e;
  logic [STALL_W-1:0] run_s, hold_s, bub_s;

  mem_stage_lsu_if #(.XLEN(XLEN), .PC_W(PC_W), .RF_AW(RF_AW), .STALL_W(STALL_W)) io ();

  mem_stage_lsu #(
    .XLEN(XLEN), .PC_W(PC_W), .RF_AW(RF_AW), .STALL_W(STALL_W),
    .MEM_IDX(MEM_IDX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(io)
  );

  always #5 clk = ~clk;

  function automatic logic [EX_W-1:0] mk_ex(
    input logic [31:0] pc, input logic en, input logic [3:0] wen, input logic [2:0] op,
    input logic sel, input logic we, input logic [4:0] wa, input logic [31:0] res);
    return {pc, en, wen, op, sel, we, wa, res};
  endfunction

  function automatic logic [WB_W-1:0] mk_wb(input logic [31:0] pc, input logic [4:0] wa,
                                             input logic [31:0] d);
    return {pc, 1'b1, wa, d};
  endfunction

  task automatic chk(input string tag, input logic [WB_W-1:0] obs, input logic [WB_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // WB consumes a result whenever its own stall bit is clear and rf_we is set.
  task automatic sb_check();
    logic [WB_W-1:0] e;
    if (!io.stall[MEM_IDX+1] && io.mem_to_wb_bus[XLEN+RF_AW]) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", io.mem_to_wb_bus, '0);
      end else begin
        e = sb_q.pop_front();
        chk("wb_data", io.mem_to_wb_bus, e);
      end
    end
  endtask

  task automatic step(input logic fl, input logic [STALL_W-1:0] st, input logic [EX_W-1:0] ex,
                      input logic rv, input logic [XLEN-1:0] rd);
    @(posedge clk);
    #1;
    io.flush           = fl;
    io.stall           = st;
    io.ex_to_mem_bus   = ex;
    io.data_rvalid     = rv;
    io.data_sram_rdata = rd;
    @(negedge clk);
    sb_check();
  endtask

  initial begin
    nop_e  = '0;
    lb_e   = mk_ex(32'h100, 1'b1, 4'h0, 3'd0, 1'b1, 1'b1, 5'd5,  32'h0000_1003);
    lhu_e  = mk_ex(32'h104, 1'b1, 4'h0, 3'd3, 1'b1, 1'b1, 5'd6,  32'h0000_1002);
    alu_e  = mk_ex(32'h108, 1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 5'd7,  32'h1234_5678);
    st_e   = mk_ex(32'h10C, 1'b1, 4'hF, 3'd0, 1'b0, 1'b0, 5'd0,  32'h0000_2000);
    lw_e   = mk_ex(32'h110, 1'b1, 4'h0, 3'd4, 1'b1, 1'b1, 5'd8,  32'h0000_3000);
    lb2_e  = mk_ex(32'h120, 1'b1, 4'h0, 3'd0, 1'b1, 1'b1, 5'd9,  32'h0000_4001);
    lh_e   = mk_ex(32'h130, 1'b1, 4'h0, 3'd2, 1'b1, 1'b1, 5'd10, 32'h0000_5001);
    lw2_e  = mk_ex(32'h140, 1'b1, 4'h0, 3'd4, 1'b1, 1'b1, 5'd11, 32'h0000_6000);
    run_s  = 6'b000000;
    hold_s = 6'b011000;
    bub_s  = 6'b001000;

    rst = 1'b1;
    io.flush = 1'b0; io.stall = run_s; io.ex_to_mem_bus = nop_e;
    io.data_rvalid = 1'b0; io.data_sram_rdata = '0;

    // Reset with busy-looking inputs: every output must stay zero.
    step(1'b0, run_s, lw_e, 1'b1, 32'hFFFF_FFFF);
    step(1'b0, run_s, lw_e, 1'b1, 32'hFFFF_FFFF);
    chk("rst_id_bus", io.mem_to_id_bus, '0);
    chk("rst_wb_bus", io.mem_to_wb_bus, '0);
    chk("rst_stallreq", io.stallreq_mem, 1'b0);
    chk("rst_align", io.align_err, 1'b0);
    chk("rst_bus_err", io.bus_err, 1'b0);
    rst = 1'b0;

    // LB off=3, data same cycle; LHU follows back-to-back.
    step(1'b0, run_s, lb_e, 1'b0, '0);
    sb_q.push_back(mk_wb(32'h100, 5'd5, 32'hFFFF_FF80));
    step(1'b0, run_s, lhu_e, 1'b1, 32'h80FF_1234);
    sb_q.push_back(mk_wb(32'h104, 5'd6, 32'h0000_8001));
    chk("lb_stallreq", io.stallreq_mem, 1'b0);
    chk("lb_id_wdata", io.mem_to_id_bus[XLEN-1:0], 32'hFFFF_FF80);
    chk("lb_id_pending", io.mem_to_id_bus[RF_AW+XLEN+1], 1'b0);

    // LHU off=2 waits three cycles for rvalid.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, hold_s, nop_e, 1'b0, 32'hAAAA_AAAA);
      chk("lhu_wait_stallreq", io.stallreq_mem, 1'b1);
      chk("lhu_wait_pending", io.mem_to_id_bus[RF_AW+XLEN+1], 1'b1);
      chk("lhu_wait_wb_we", io.mem_to_wb_bus[XLEN+RF_AW], 1'b0);
    end
    step(1'b0, run_s, alu_e, 1'b1, 32'h8001_0000);
    sb_q.push_back(mk_wb(32'h108, 5'd7, 32'h1234_5678));
    chk("lhu_wb_bus", io.mem_to_wb_bus, mk_wb(32'h104, 5'd6, 32'h0000_8001));
    chk("lhu_stallreq", io.stallreq_mem, 1'b0);

    // ALU op passes ex_result, store never stalls or writes back.
    step(1'b0, run_s, st_e, 1'b0, '0);
    chk("alu_stallreq", io.stallreq_mem, 1'b0);
    step(1'b0, run_s, lw_e, 1'b0, '0);
    sb_q.push_back(mk_wb(32'h110, 5'd8, 32'h8001_0000));
    chk("st_stallreq", io.stallreq_mem, 1'b0);
    chk("st_align", io.align_err, 1'b0);
    chk("st_wb_we", io.mem_to_wb_bus[XLEN+RF_AW], 1'b0);

    // LW returns while WB is stalled: buffered, stray rvalid ignored, then bubble.
    step(1'b0, hold_s, nop_e, 1'b1, 32'h8001_0000);
    chk("lw_rv_stallreq", io.stallreq_mem, 1'b0);
    step(1'b0, hold_s, nop_e, 1'b1, 32'hDEAD_BEEF);
    chk("lw_buf_wdata", io.mem_to_wb_bus[XLEN-1:0], 32'h8001_0000);
    chk("lw_buf_stallreq", io.stallreq_mem, 1'b0);
    step(1'b0, bub_s, nop_e, 1'b0, '0);
    step(1'b0, run_s, nop_e, 1'b0, '0);
    chk("bubble_wb_bus", io.mem_to_wb_bus, '0);

    // Flush during WAIT, late rvalid two cycles on.
    step(1'b0, run_s, lb2_e, 1'b0, '0);
    step(1'b1, hold_s, nop_e, 1'b0, '0);
    chk("flush_wait_stallreq", io.stallreq_mem, 1'b1);
    step(1'b0, run_s, nop_e, 1'b0, '0);
    chk("flush_stallreq", io.stallreq_mem, 1'b0);
    chk("flush_wb_bus", io.mem_to_wb_bus, '0);
    step(1'b0, run_s, nop_e, 1'b1, 32'h1111_1111);
    chk("late_rv_stallreq", io.stallreq_mem, 1'b0);
    chk("late_rv_wb_we", io.mem_to_wb_bus[XLEN+RF_AW], 1'b0);
    chk("late_rv_wb_bus", io.mem_to_wb_bus, '0);

    // LH off=1: misaligned, extracted as off=0.
    step(1'b0, run_s, lh_e, 1'b0, '0);
    sb_q.push_back(mk_wb(32'h130, 5'd10, 32'hFFFF_F00D));
    step(1'b0, run_s, nop_e, 1'b1, 32'h1234_F00D);
    chk("lh_align", io.align_err, 1'b1);
    step(1'b0, run_s, nop_e, 1'b0, '0);
    chk("nop_align", io.align_err, 1'b0);

    // Watchdog: no rvalid for TIMEOUT cycles.
    step(1'b0, run_s, lw2_e, 1'b0, '0);
    sb_q.push_back(mk_wb(32'h140, 5'd11, 32'h0000_0000));
    for (int i = 0; i < TIMEOUT; i++) begin
      step(1'b0, hold_s, nop_e, 1'b0, '0);
      chk("wd_wait_stallreq", io.stallreq_mem, 1'b1);
      chk("wd_wait_bus_err", io.bus_err, 1'b0);
    end
    step(1'b0, hold_s, nop_e, 1'b0, '0);
    chk("wd_bus_err", io.bus_err, 1'b1);
    chk("wd_stallreq", io.stallreq_mem, 1'b0);
    step(1'b0, run_s, nop_e, 1'b0, '0);
    step(1'b0, run_s, nop_e, 1'b0, '0);
    chk("wd_sticky", io.bus_err, 1'b1);
    rst = 1'b1;
    step(1'b0, run_s, nop_e, 1'b0, '0);
    chk("rst_clears_bus_err", io.bus_err, 1'b0);
    rst = 1'b0;

    chk("sb_drained", sb_q.size(), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
